// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator with pixel-rate enable,
// h/v counters, coordinate export and a latency-matched sync/colour output.
//
// Ports:
//   clk_100m    system clock
//   rst         synchronous active-high reset
//   pix_rgb     colour {r,g,b} returned LAT pixel ticks after its coordinate
//   pix_ce      pixel tick enable, one clk wide every DIV clks
//   pix_x/pix_y current horizontal/vertical counters
//   pix_valid   counters lie in the visible region
//   frame_start pulse on the pix_ce at (0,0)
//   line_start  pulse on the pix_ce at h==0
//   vga_hsync/vga_vsync, vga_r/vga_g/vga_b  registered pin outputs

module vga_timing_gen #(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LAT      = 1,
    parameter int RW       = 3,
    parameter int GW       = 3,
    parameter int BW       = 2
) (
    input  logic                clk_100m,
    input  logic                rst,
    input  logic [RW+GW+BW-1:0] pix_rgb,
    output logic                pix_ce,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] pix_x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] pix_y,
    output logic                pix_valid,
    output logic                frame_start,
    output logic                line_start,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic [RW-1:0]       vga_r,
    output logic [GW-1:0]       vga_g,
    output logic [BW-1:0]       vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW      = RW + GW + BW;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_last;
    logic          v_last;
    logic [31:0]   hx;
    logic [31:0]   vx;
    logic          hs_raw;
    logic          vs_raw;
    logic          act_raw;
    logic          hs_d;
    logic          vs_d;
    logic          act_d;

    // Pixel-rate divider; with DIV=1 the count sits at 0 == DIV-1.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == DW'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign pix_ce = (div_cnt == DW'(DIV - 1)) && !rst;

    assign h_last = (h == HW'(H_TOTAL - 1));
    assign v_last = (v == VW'(V_TOTAL - 1));

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (pix_ce) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    assign pix_x = h;
    assign pix_y = v;

    // Widened copies so region bounds equal to the total never overflow.
    assign hx = 32'(h);
    assign vx = 32'(v);

    assign act_raw = (hx < 32'(H_ACTIVE)) && (vx < 32'(V_ACTIVE));
    assign hs_raw  = (hx >= 32'(HS_BEG)) && (hx < 32'(HS_END));
    assign vs_raw  = (vx >= 32'(VS_BEG)) && (vx < 32'(VS_END));

    assign pix_valid   = act_raw && !rst;
    assign line_start  = pix_ce && (h == '0);
    assign frame_start = pix_ce && (h == '0) && (v == '0);

    // Sync/active delay matching the colour source return latency.
    generate
        if (LAT == 0) begin : g_nodly
            assign hs_d  = hs_raw;
            assign vs_d  = vs_raw;
            assign act_d = act_raw;
        end else begin : g_dly
            logic [LAT-1:0] hs_sr;
            logic [LAT-1:0] vs_sr;
            logic [LAT-1:0] act_sr;

            always_ff @(posedge clk_100m) begin
                if (rst) begin
                    hs_sr  <= '0;
                    vs_sr  <= '0;
                    act_sr <= '0;
                end else if (pix_ce) begin
                    hs_sr  <= LAT'({hs_sr, hs_raw});
                    vs_sr  <= LAT'({vs_sr, vs_raw});
                    act_sr <= LAT'({act_sr, act_raw});
                end
            end

            assign hs_d  = hs_sr[LAT-1];
            assign vs_d  = vs_sr[LAT-1];
            assign act_d = act_sr[LAT-1];
        end
    endgenerate

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            vga_hsync <= ~HS_POL;
            vga_vsync <= ~VS_POL;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else if (pix_ce) begin
            vga_hsync <= hs_d ^ ~HS_POL;
            vga_vsync <= vs_d ^ ~VS_POL;
            vga_r     <= act_d ? pix_rgb[CW-1 -: RW] : '0;
            vga_g     <= act_d ? pix_rgb[BW +: GW]   : '0;
            vga_b     <= act_d ? pix_rgb[0 +: BW]    : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen covering default,
// long-latency and tiny configurations.

module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -100000;
    endfunction

    // ---------------- default instance ----------------
    logic       rst_def;
    logic [7:0] def_rgb_in;
    logic       def_ce, def_valid, def_fs, def_ls, def_hs, def_vs;
    logic [9:0] def_x, def_y;
    logic [2:0] def_r, def_g;
    logic [1:0] def_b;

    vga_timing_gen u_def (
        .clk_100m(clk), .rst(rst_def), .pix_rgb(def_rgb_in),
        .pix_ce(def_ce), .pix_x(def_x), .pix_y(def_y),
        .pix_valid(def_valid), .frame_start(def_fs),
        .line_start(def_ls), .vga_hsync(def_hs), .vga_vsync(def_vs),
        .vga_r(def_r), .vga_g(def_g), .vga_b(def_b)
    );

    // ---------------- LAT=3 reduced geometry ----------------
    logic       rst_lat;
    logic [7:0] lat_rgb_in;
    logic       lat_ce, lat_valid, lat_fs, lat_ls, lat_hs, lat_vs;
    logic [4:0] lat_x;
    logic [3:0] lat_y;
    logic [2:0] lat_r, lat_g;
    logic [1:0] lat_b;

    vga_timing_gen #(
        .DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1), .LAT(3)
    ) u_lat (
        .clk_100m(clk), .rst(rst_lat), .pix_rgb(lat_rgb_in),
        .pix_ce(lat_ce), .pix_x(lat_x), .pix_y(lat_y),
        .pix_valid(lat_valid), .frame_start(lat_fs),
        .line_start(lat_ls), .vga_hsync(lat_hs), .vga_vsync(lat_vs),
        .vga_r(lat_r), .vga_g(lat_g), .vga_b(lat_b)
    );

    // ---------------- tiny config, DIV=1, HS_POL=1 ----------------
    logic       rst_sml;
    logic [7:0] sml_rgb_in;
    logic       sml_ce, sml_valid, sml_fs, sml_ls, sml_hs, sml_vs;
    logic [3:0] sml_x;
    logic [2:0] sml_y;
    logic [2:0] sml_r, sml_g;
    logic [1:0] sml_b;

    vga_timing_gen #(
        .DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)
    ) u_sml (
        .clk_100m(clk), .rst(rst_sml), .pix_rgb(sml_rgb_in),
        .pix_ce(sml_ce), .pix_x(sml_x), .pix_y(sml_y),
        .pix_valid(sml_valid), .frame_start(sml_fs),
        .line_start(sml_ls), .vga_hsync(sml_hs), .vga_vsync(sml_vs),
        .vga_r(sml_r), .vga_g(sml_g), .vga_b(sml_b)
    );

    // ---------------- colour source for u_lat ----------------
    function automatic logic [7:0] src_col(input int x, input int y);
        if (x < 16 && y < 6) return 8'(x * 8 + y + 1);
        return 8'hFF;
    endfunction

    function automatic logic [9:0] lat_exp(input int x, input int y);
        logic       hs;
        logic       vs;
        logic [7:0] c;
        hs = !(x >= 18 && x < 21);
        vs = (y != 7);
        c  = (x < 16 && y < 6) ? 8'(x * 8 + y + 1) : 8'h00;
        return {hs, vs, c};
    endfunction

    int sx0, sx1, sx2, sy0, sy1, sy2;
    always @(posedge clk) begin
        if (rst_lat) begin
            sx0 <= 99; sx1 <= 99; sx2 <= 99;
            sy0 <= 99; sy1 <= 99; sy2 <= 99;
        end else if (lat_ce) begin
            sx2 <= sx1; sx1 <= sx0; sx0 <= int'(lat_x);
            sy2 <= sy1; sy1 <= sy0; sy0 <= int'(lat_y);
        end
    end
    assign lat_rgb_in = src_col(sx2, sy2);

    // ---------------- monitors ----------------
    bit mon_en = 1'b0;
    bit lat_mon_en = 1'b0;

    int def_hs_fall[$], def_hs_rise[$], def_ls_t[$];
    int def_fs_n = 0, def_vs_low = 0, def_x656 = -1;
    int def_rgb_at_fall = -1;
    bit def_hs_prev = 1'b1;

    always @(negedge clk) if (mon_en) begin
        if (def_hs_prev && !def_hs) begin
            def_hs_fall.push_back(cyc);
            if (def_rgb_at_fall < 0)
                def_rgb_at_fall <= int'({def_r, def_g, def_b});
        end
        if (!def_hs_prev && def_hs) def_hs_rise.push_back(cyc);
        def_hs_prev <= def_hs;
        if (def_ls) def_ls_t.push_back(cyc);
        if (def_fs) def_fs_n <= def_fs_n + 1;
        if (!def_vs) def_vs_low <= def_vs_low + 1;
        if (def_x656 < 0 && def_x == 10'd656) def_x656 <= cyc;
    end

    int sml_hs_rise[$], sml_hs_fall[$], sml_vs_fall[$], sml_vs_rise[$];
    int sml_fs_t[$];
    bit sml_hs_prev = 1'b0;
    bit sml_vs_prev = 1'b1;

    always @(negedge clk) if (mon_en) begin
        if (!sml_hs_prev && sml_hs) sml_hs_rise.push_back(cyc);
        if (sml_hs_prev && !sml_hs) sml_hs_fall.push_back(cyc);
        if (sml_vs_prev && !sml_vs) sml_vs_fall.push_back(cyc);
        if (!sml_vs_prev && sml_vs) sml_vs_rise.push_back(cyc);
        sml_hs_prev <= sml_hs;
        sml_vs_prev <= sml_vs;
        if (sml_fs) sml_fs_t.push_back(cyc);
    end

    int lat_cx[4096];
    int lat_cy[4096];
    int lat_n = 0, lat_bad = 0, lat_checked = 0, lat_ff = 0;
    int lat_t_wrap = -1, lat_t_pin = -1;
    int lat_px_prev = 0, lat_py_prev = 0;
    bit lat_prev_ce = 1'b0;

    always @(negedge clk) if (lat_mon_en) begin
        if (lat_prev_ce && lat_n > 0) begin
            if ({lat_hs, lat_vs, lat_r, lat_g, lat_b} !==
                ((lat_n >= 4) ? lat_exp(lat_cx[lat_n-4], lat_cy[lat_n-4])
                              : 10'h300))
                lat_bad <= lat_bad + 1;
            lat_checked <= lat_checked + 1;
            if ({lat_r, lat_g, lat_b} == 8'hFF) lat_ff <= lat_ff + 1;
        end
        if (lat_ce && lat_n < 4096) begin
            lat_cx[lat_n] <= int'(lat_x);
            lat_cy[lat_n] <= int'(lat_y);
            lat_n <= lat_n + 1;
        end
        lat_prev_ce <= lat_ce;
        if (lat_t_wrap < 0 && lat_x == 5'd0 && lat_y == 4'd0 &&
            !(lat_px_prev == 0 && lat_py_prev == 0))
            lat_t_wrap <= cyc;
        if (lat_t_wrap >= 0 && lat_t_pin < 0 &&
            {lat_r, lat_g, lat_b} == 8'd1)
            lat_t_pin <= cyc;
        lat_px_prev <= int'(lat_x);
        lat_py_prev <= int'(lat_y);
    end

    // ---------------- startup vectors for u_def ----------------
    typedef struct {
        int k;
        bit ce;
        bit fs;
        bit ls;
        int x;
        bit valid;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int idx;
        int k;
        int t_first;
        int t_hs;
        bit found;

        tbl[0]  = '{0,  1'b0, 1'b0, 1'b0, 0, 1'b1};
        tbl[1]  = '{1,  1'b0, 1'b0, 1'b0, 0, 1'b1};
        tbl[2]  = '{2,  1'b0, 1'b0, 1'b0, 0, 1'b1};
        tbl[3]  = '{3,  1'b1, 1'b1, 1'b1, 0, 1'b1};
        tbl[4]  = '{4,  1'b0, 1'b0, 1'b0, 1, 1'b1};
        tbl[5]  = '{6,  1'b0, 1'b0, 1'b0, 1, 1'b1};
        tbl[6]  = '{7,  1'b1, 1'b0, 1'b0, 1, 1'b1};
        tbl[7]  = '{8,  1'b0, 1'b0, 1'b0, 2, 1'b1};
        tbl[8]  = '{11, 1'b1, 1'b0, 1'b0, 2, 1'b1};
        tbl[9]  = '{15, 1'b1, 1'b0, 1'b0, 3, 1'b1};
        tbl[10] = '{16, 1'b0, 1'b0, 1'b0, 4, 1'b1};
        tbl[11] = '{19, 1'b1, 1'b0, 1'b0, 4, 1'b1};

        rst_def = 1'b1;
        rst_lat = 1'b1;
        rst_sml = 1'b1;
        def_rgb_in = 8'hFF;
        sml_rgb_in = 8'h5A;

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("rst_def_hsync", int'(def_hs), 1);
        chk("rst_def_vsync", int'(def_vs), 1);
        chk("rst_def_rgb", int'({def_r, def_g, def_b}), 0);
        chk("rst_def_ce", int'(def_ce), 0);
        chk("rst_def_valid", int'(def_valid), 0);
        chk("rst_def_fs", int'(def_fs), 0);
        chk("rst_def_x", int'(def_x), 0);
        chk("rst_sml_hsync", int'(sml_hs), 0);
        chk("rst_sml_ce", int'(sml_ce), 0);
        chk("rst_lat_rgb", int'({lat_r, lat_g, lat_b}), 0);

        @(posedge clk);
        #1;
        rst_def = 1'b0;
        rst_lat = 1'b0;
        rst_sml = 1'b0;
        mon_en = 1'b1;
        lat_mon_en = 1'b1;

        t0 = 0;
        idx = -1;
        for (int i = 0; i < 12; i++) begin
            while (idx < tbl[i].k) begin
                @(negedge clk);
                idx++;
                if (idx == 0) t0 = cyc;
            end
            chk($sformatf("start%0d_ce", tbl[i].k), int'(def_ce),
                int'(tbl[i].ce));
            chk($sformatf("start%0d_fs", tbl[i].k), int'(def_fs),
                int'(tbl[i].fs));
            chk($sformatf("start%0d_ls", tbl[i].k), int'(def_ls),
                int'(tbl[i].ls));
            chk($sformatf("start%0d_x", tbl[i].k), int'(def_x), tbl[i].x);
            chk($sformatf("start%0d_valid", tbl[i].k), int'(def_valid),
                int'(tbl[i].valid));
        end

        repeat (10000) @(negedge clk);
        lat_mon_en = 1'b0;

        chk("def_first_ls", qat(def_ls_t, 0) - t0, 3);
        chk("def_ls_period", qat(def_ls_t, 1) - qat(def_ls_t, 0), 3200);
        chk("def_hs_period",
            qat(def_hs_fall, 1) - qat(def_hs_fall, 0), 3200);
        chk("def_hs_low", qat(def_hs_rise, 0) - qat(def_hs_fall, 0), 384);
        chk("def_hs_after_656", qat(def_hs_fall, 0) - def_x656, 8);
        chk("def_rgb_in_sync", def_rgb_at_fall, 0);
        chk("def_fs_count", def_fs_n, 1);
        chk("def_vs_low", def_vs_low, 0);

        chk("sml_first_fs", qat(sml_fs_t, 0) - t0, 0);
        chk("sml_fs_period", qat(sml_fs_t, 1) - qat(sml_fs_t, 0), 98);
        chk("sml_hs_period",
            qat(sml_hs_rise, 1) - qat(sml_hs_rise, 0), 14);
        chk("sml_hs_high", qat(sml_hs_fall, 0) - qat(sml_hs_rise, 0), 2);
        chk("sml_vs_low", qat(sml_vs_rise, 0) - qat(sml_vs_fall, 0), 14);
        chk("sml_vs_period",
            qat(sml_vs_fall, 1) - qat(sml_vs_fall, 0), 98);

        chk("lat_pin_mismatches", lat_bad, 0);
        chk("lat_blank_ff", lat_ff, 0);
        chk("lat_enough_ticks", int'(lat_checked > 1000), 1);
        chk("lat_origin_delay", lat_t_pin - lat_t_wrap, 16);

        // Mid-frame reset on u_lat at (x=10, y=5).
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (lat_x == 5'd10 && lat_y == 4'd5) found = 1'b1;
        end
        chk("mid_found", int'(found), 1);
        rst_lat = 1'b1;
        @(posedge clk);
        #1;
        rst_lat = 1'b0;
        chk("mid_x", int'(lat_x), 0);
        chk("mid_y", int'(lat_y), 0);
        chk("mid_hsync", int'(lat_hs), 1);
        chk("mid_vsync", int'(lat_vs), 1);
        chk("mid_rgb", int'({lat_r, lat_g, lat_b}), 0);

        k = 0;
        found = 1'b0;
        for (int i = 1; i <= 8 && !found; i++) begin
            @(negedge clk);
            if (lat_ce) begin
                found = 1'b1;
                k = i;
            end
        end
        chk("mid_first_ce", k, 4);
        chk("mid_first_fs", int'(lat_fs), 1);
        t_first = cyc;

        t_hs = -1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (t_hs < 0 && !lat_hs) t_hs = cyc;
            if (lat_fs) found = 1'b1;
        end
        chk("mid_frame_period", found ? cyc - t_first : -1, 864);
        chk("mid_hs_fall", t_hs - t_first, 85);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
